// File: rtl/conv_stream_pkg.sv
// Shared types and defaults for the conv input-stream source.
// The state enum, default sizes and a small helper live here.
package conv_stream_pkg;

  typedef enum logic {IDLE, PLAY} src_state_t;

  localparam int T_DEFAULT     = 16;
  localparam int DEPTH_DEFAULT = 9984;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_stream_if.sv
// Load-side and stream-side valid/ready handshakes of the stream source.
// The master modport is the source itself; the slave modport is the host/consumer side.
interface conv_stream_if
  import conv_stream_pkg::*;
#(
  parameter int T = T_DEFAULT
);

  logic [T-1:0] ld_data;
  logic         ld_valid;
  logic         ld_ready;
  logic [T-1:0] m_data_out_x;
  logic         m_valid_x;
  logic         m_ready_x;

  modport master (
    input  ld_data, ld_valid, m_ready_x,
    output ld_ready, m_data_out_x, m_valid_x
  );

  modport slave (
    output ld_data, ld_valid, m_ready_x,
    input  ld_ready, m_data_out_x, m_valid_x
  );

endinterface

// File: rtl/conv_stream_ram.sv
// Single-port sample store with a registered read port.
// Loading and playback never overlap, so one shared address is enough.
module conv_stream_ram #(
  parameter int T     = 16,
  parameter int DEPTH = 9984,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [T-1:0]  wdata,
  output logic [T-1:0]  rdata
);

  logic [T-1:0] mem [DEPTH];
  logic [T-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_stream_source.sv
// Replays a host-loaded block of samples on a valid/ready stream to a conv layer.
// Holds the load counter, the IDLE/PLAY control and a 2-entry output skid buffer.
module conv_stream_source
  import conv_stream_pkg::*;
#(
  parameter int T     = T_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  conv_stream_if.master              io,
  input  logic                       clear,
  input  logic                       start,
  input  logic [$clog2(DEPTH+1)-1:0] num_vals,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  src_state_t   state_q, state_d;
  logic [AW-1:0] wr_count_q, wr_count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] out_cnt_q, out_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [T-1:0]  buf_q [2];
  logic [T-1:0]  buf_d [2];
  logic [1:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          ld_ready;
  logic          ld_fire;
  logic          pop;
  logic          rd_issue;
  logic [2:0]    occ_next;
  logic [1:0]    slot;
  logic [AW-1:0] len_start;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [T-1:0]  ram_rdata;

  assign ld_ready = (state_q == IDLE) && (wr_count_q < DEPTH_W) && !clear;
  assign ld_fire  = io.ld_valid && ld_ready;
  assign pop      = (cnt_q != 2'd0) && io.m_ready_x;

  // A read may only go out if its data is sure to find a free buffer slot when it lands.
  assign occ_next = {1'b0, cnt_q} + {2'b00, rd_valid_q} + 3'd1 - {2'b00, pop};
  assign rd_issue = (state_q == PLAY) && (rd_ptr_q < len_q) && (occ_next <= 3'd2);

  assign ram_en   = ld_fire || rd_issue;
  assign ram_addr = (state_q == PLAY) ? rd_ptr_q : wr_count_q;

  conv_stream_ram #(
    .T     (T),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ld_fire),
    .addr  (ram_addr),
    .wdata (io.ld_data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    out_cnt_d  = out_cnt_q;
    rd_valid_d = rd_issue;
    buf_d      = buf_q;
    done_d     = 1'b0;
    slot       = 2'd0;
    len_start  = AW'(min_u(32'(num_vals), 32'(wr_count_q)));

    if (pop) begin
      buf_d[0]  = buf_q[1];
      out_cnt_d = out_cnt_q + AW'(1);
    end
    // Returning read data goes behind whatever survives this cycle's pop.
    if (rd_valid_q) begin
      slot = pop ? (cnt_q - 2'd1) : cnt_q;
      if (slot == 2'd0) begin
        buf_d[0] = ram_rdata;
      end else begin
        buf_d[1] = ram_rdata;
      end
    end
    cnt_d = cnt_q - {1'b0, pop} + {1'b0, rd_valid_q};

    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case (state_q)
      IDLE: begin
        if (clear) begin
          wr_count_d = '0;
        end else begin
          if (ld_fire) begin
            wr_count_d = wr_count_q + AW'(1);
          end
          if (start) begin
            if (len_start == '0) begin
              done_d = 1'b1;
            end else begin
              state_d   = PLAY;
              len_d     = len_start;
              rd_ptr_d  = '0;
              out_cnt_d = '0;
            end
          end
        end
      end
      PLAY: begin
        if (pop && (out_cnt_q == len_q - AW'(1))) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          rd_ptr_d  = '0;
          out_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      out_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      cnt_q      <= 2'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      out_cnt_q  <= out_cnt_d;
      rd_valid_q <= rd_valid_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign io.ld_ready     = ld_ready;
  assign io.m_valid_x    = (cnt_q != 2'd0);
  assign io.m_data_out_x = buf_q[0];
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_conv_stream_source.sv
// Self-checking bench for conv_stream_source: a queue of accepted load samples is the
// reference; each playback is compared against its first min(num_vals, size) entries.
module tb_conv_stream_source;
  import conv_stream_pkg::*;

  localparam int T     = 16;
  localparam int DEPTH = 9984;
  localparam int AW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          start;
  logic [AW-1:0] num_vals;
  logic          busy;
  logic          done;

  conv_stream_if #(.T(T)) bus ();

  conv_stream_source #(
    .T     (T),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .io       (bus.master),
    .clear    (clear),
    .start    (start),
    .num_vals (num_vals),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [T-1:0] model_q [$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offers count load beats; the model accepts a beat while it holds fewer than DEPTH samples.
  task automatic applyStimulus(input int count, input bit use_random);
    logic [T-1:0] v;
    for (int i = 0; i < count; i++) begin
      v = use_random ? T'($urandom()) : T'(i + 1);
      bus.ld_data  = v;
      bus.ld_valid = 1'b1;
      @(negedge clk);
      checkOutput("ld_ready", int'(bus.ld_ready), int'(model_q.size() < DEPTH));
      @(posedge clk);
      if (model_q.size() < DEPTH) model_q.push_back(v);
      #1;
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic clearBuffer();
    clear        = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hBEEF;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.ld_valid = 1'b0;
    model_q.delete();
  endtask

  // Cycle index 0 is the negedge just after the edge that samples start.
  task automatic runPlayback(input int n, input bit random_ready);
    int exp_len, cyc, done_cyc, first_cyc, bound;
    bit finished, hold_pending;
    logic [T-1:0] held;
    logic [T-1:0] got_q [$];
    exp_len      = (n < model_q.size()) ? n : model_q.size();
    bound        = 4 * exp_len + 20;
    start        = 1'b1;
    num_vals     = AW'(n);
    bus.m_ready_x = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    @(posedge clk);
    #1;
    start         = 1'b0;
    bus.m_ready_x = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    cyc = 0; finished = 0; hold_pending = 0; done_cyc = -1; first_cyc = -1; held = '0;
    while (!finished && cyc < bound) begin
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput("busy_on_start", int'(busy), int'(exp_len > 0));
        checkOutput("ld_ready_on_start", int'(bus.ld_ready),
                    int'(exp_len == 0 && model_q.size() < DEPTH));
      end
      if (hold_pending) begin
        checkOutput("stall_valid", int'(bus.m_valid_x), 1);
        checkOutput("stall_data", int'(bus.m_data_out_x), int'(held));
      end
      if (bus.m_valid_x && first_cyc < 0) first_cyc = cyc;
      if (bus.m_valid_x && bus.m_ready_x) got_q.push_back(bus.m_data_out_x);
      hold_pending = bus.m_valid_x && !bus.m_ready_x;
      held         = bus.m_data_out_x;
      if (done) begin
        finished = 1;
        done_cyc = cyc;
        checkOutput("valid_at_done", int'(bus.m_valid_x), 0);
        checkOutput("busy_at_done", int'(busy), 0);
      end else begin
        @(posedge clk);
        #1;
        if (random_ready) bus.m_ready_x = ($urandom_range(0, 1) == 1);
        cyc++;
      end
    end
    checkOutput("done_seen", int'(finished), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("done_one_cycle", int'(done), 0);
    checkOutput("valid_idle", int'(bus.m_valid_x), 0);
    if (!random_ready || exp_len == 0)
      checkOutput("done_cyc", done_cyc, (exp_len == 0) ? 0 : exp_len + 2);
    if (!random_ready && exp_len > 0)
      checkOutput("first_valid_cyc", first_cyc, 2);
    checkOutput("beat_count", got_q.size(), exp_len);
    for (int i = 0; i < got_q.size() && i < exp_len; i++)
      checkOutput("beat_data", int'(got_q[i]), int'(model_q[i]));
    @(posedge clk);
    #1;
  endtask

  // Reset lands right after the third accepted beat of a five-beat replay.
  task automatic resetMidPlay();
    int hs, cyc;
    start         = 1'b1;
    num_vals      = AW'(5);
    bus.m_ready_x = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 20) begin
      @(negedge clk);
      if (bus.m_valid_x && bus.m_ready_x) begin
        checkOutput("pre_reset_data", int'(bus.m_data_out_x), int'(model_q[hs]));
        hs++;
      end
      if (hs < 3) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    checkOutput("hs_before_reset", hs, 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_q.delete();
    @(negedge clk);
    checkOutput("rst_valid", int'(bus.m_valid_x), 0);
    checkOutput("rst_ld_ready", int'(bus.ld_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    clear         = 1'b0;
    start         = 1'b0;
    num_vals      = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.m_ready_x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", int'(bus.m_valid_x), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_ld_ready", int'(bus.ld_ready), 1);
    @(posedge clk);
    #1;

    $display("[TB] empty buffer start");
    runPlayback(5, 1'b0);

    $display("[TB] load 1..5, replay twice with ready high");
    applyStimulus(5, 1'b0);
    runPlayback(5, 1'b0);
    runPlayback(5, 1'b0);

    $display("[TB] random backpressure");
    repeat (3) runPlayback(5, 1'b1);

    $display("[TB] length clamped to buffer fill");
    runPlayback(9, 1'b0);

    $display("[TB] clear then start");
    clearBuffer();
    runPlayback(5, 1'b0);

    $display("[TB] full buffer load and replay");
    applyStimulus(DEPTH + 3, 1'b1);
    runPlayback(DEPTH, 1'b0);

    $display("[TB] reset during playback");
    clearBuffer();
    applyStimulus(5, 1'b0);
    resetMidPlay();
    runPlayback(5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
